ats_eligibility_scheduler: RTL and testbench

- Computes the per-frame ATS (802.1Qcr token-bucket) eligibility time and drives the timestamp stream consumed by the frame/timestamp joiner.
- Takes one request per frame (arrival time, frame length) from the ingress parser.
- Emits one timestamp beat per request: a non-zero eligibility time, or 0 to mark the frame for discard.
- Holds one scheduler instance's bucket state: bucket-empty time and group eligibility time.

---
 rtl/ats_eligibility_scheduler.sv | 105 ++++++++++
 tb/tb_ats_eligibility_scheduler.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ats_eligibility_scheduler.sv
// ats_eligibility_scheduler: ATS token-bucket eligibility time per request (s_req_* in, m_axis_timestamp_* out, 0 = discard), cfg_* sampled at accept, stat_* pass/drop counters
module ats_eligibility_scheduler #(
  parameter int TIMESTAMP_WIDTH = 72,
  parameter int LENGTH_WIDTH    = 16,
  parameter int RATE_WIDTH      = 16,
  parameter int COUNTER_WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [TIMESTAMP_WIDTH-1:0] s_req_arrival,
  input  logic [LENGTH_WIDTH-1:0]    s_req_length,
  input  logic                       s_req_valid,
  output logic                       s_req_ready,
  output logic [TIMESTAMP_WIDTH-1:0] m_axis_timestamp_tdata,
  output logic                       m_axis_timestamp_tvalid,
  input  logic                       m_axis_timestamp_tready,
  input  logic [RATE_WIDTH-1:0]      cfg_ns_per_byte,
  input  logic [TIMESTAMP_WIDTH-1:0] cfg_empty_to_full,
  input  logic [TIMESTAMP_WIDTH-1:0] cfg_max_residence,
  input  logic                       cfg_clear,
  output logic [COUNTER_WIDTH-1:0]   stat_pass_count,
  output logic [COUNTER_WIDTH-1:0]   stat_drop_count
);
  localparam int TW = TIMESTAMP_WIDTH;
  localparam int DW = LENGTH_WIDTH + RATE_WIDTH;
  typedef enum logic [2:0] {IDLE, CALC_A, CALC_B, CALC_C, OUT} state_t;
  state_t state, state_nx;
  logic [TW-1:0] arr_q, e2f_q, mres_q, be_q, ge_q, result_q;
  logic [LENGTH_WIDTH-1:0] len_q;
  logic [RATE_WIDTH-1:0] npb_q;
  logic [TW:0] sched_q, full_q, elig_q, limit_q;
  logic [TW:0] arr_x, ge_x, max_ag, elig_nx, be_nx;
  logic [DW-1:0] len_dur;
  logic pend_q, pass;
  assign s_req_ready = state == IDLE;
  assign m_axis_timestamp_tvalid = state == OUT;
  assign m_axis_timestamp_tdata = result_q;
  assign len_dur = len_q * npb_q;
  assign arr_x = {1'b0, arr_q};
  assign ge_x = {1'b0, ge_q};
  assign max_ag = arr_x > ge_x ? arr_x : ge_x;
  assign elig_nx = max_ag > sched_q ? max_ag : sched_q;
  // elig >= full here, so the excess over full only ever grows the bucket time
  assign be_nx = sched_q + elig_q - full_q;
  // a carry out of any sum makes elig exceed every limit
  assign pass = !elig_q[TW] && elig_q <= limit_q;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE   ? (s_req_valid ? CALC_A : IDLE) :
               state == CALC_A ? CALC_B :
               state == CALC_B ? CALC_C :
               state == CALC_C ? OUT :
               (m_axis_timestamp_tready ? IDLE : OUT);
  end
  always_ff @(posedge clk) state <= !rstn ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      {arr_q, e2f_q, mres_q, be_q, ge_q, result_q, len_q, npb_q} <= '0;
      {sched_q, full_q, elig_q, limit_q, pend_q} <= '0;
      stat_pass_count <= '0;
      stat_drop_count <= '0;
    end else begin
      if (state != IDLE && cfg_clear) pend_q <= 1'b1;
      case (state)
        IDLE: begin
          if (cfg_clear) begin
            be_q <= '0;
            ge_q <= '0;
          end
          if (s_req_valid) begin
            arr_q <= s_req_arrival;
            len_q <= s_req_length;
            npb_q <= cfg_ns_per_byte;
            e2f_q <= cfg_empty_to_full;
            mres_q <= cfg_max_residence;
          end
        end
        CALC_A: begin
          sched_q <= {1'b0, be_q} + {{(TW+1-DW){1'b0}}, len_dur};
          full_q <= {1'b0, be_q} + {1'b0, e2f_q};
        end
        CALC_B: begin
          elig_q <= elig_nx;
          limit_q <= arr_x + {1'b0, mres_q};
        end
        CALC_C: begin
          if (pass) begin
            ge_q <= elig_q[TW-1:0];
            be_q <= elig_q < full_q ? sched_q[TW-1:0] : be_nx[TW-1:0];
          end
          result_q <= !pass ? '0 : elig_q[TW-1:0] == '0 ? TW'(1) : elig_q[TW-1:0];
        end
        default: if (m_axis_timestamp_tready) begin
          if (result_q != '0) stat_pass_count <= stat_pass_count + COUNTER_WIDTH'(stat_pass_count != '1);
          else stat_drop_count <= stat_drop_count + COUNTER_WIDTH'(stat_drop_count != '1);
          if (pend_q || cfg_clear) begin
            be_q <= '0;
            ge_q <= '0;
          end
          pend_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ats_eligibility_scheduler.sv
// tb_ats_eligibility_scheduler: directed scoreboard bench for ats_eligibility_scheduler
module tb_ats_eligibility_scheduler;
  logic clk = 0, rstn = 0;
  logic [71:0] s_req_arrival = 0, m_axis_timestamp_tdata;
  logic [15:0] s_req_length = 0, cfg_ns_per_byte = 8;
  logic s_req_valid = 0, s_req_ready, m_axis_timestamp_tvalid, m_axis_timestamp_tready = 0;
  logic [71:0] cfg_empty_to_full = 12000, cfg_max_residence = 100000;
  logic cfg_clear = 0;
  logic [31:0] stat_pass_count, stat_drop_count;
  logic [71:0] exp_q[$];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  ats_eligibility_scheduler dut (
    .clk(clk), .rstn(rstn),
    .s_req_arrival(s_req_arrival), .s_req_length(s_req_length),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .m_axis_timestamp_tdata(m_axis_timestamp_tdata),
    .m_axis_timestamp_tvalid(m_axis_timestamp_tvalid),
    .m_axis_timestamp_tready(m_axis_timestamp_tready),
    .cfg_ns_per_byte(cfg_ns_per_byte), .cfg_empty_to_full(cfg_empty_to_full),
    .cfg_max_residence(cfg_max_residence), .cfg_clear(cfg_clear),
    .stat_pass_count(stat_pass_count), .stat_drop_count(stat_drop_count)
  );
  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rstn = 0;
    step();
    rstn = 1;
  endtask
  // drive one request, optionally pulse cfg_clear during CALC_A / at accept, hold tready low for 'hold' cycles
  task automatic req(input logic [71:0] arr, input logic [15:0] len, input logic [71:0] exp,
                     input bit clr_a, input bit clr_accept, input int hold);
    int lat;
    logic [71:0] held;
    logic [31:0] pc, dc;
    s_req_arrival = arr;
    s_req_length = len;
    s_req_valid = 1;
    exp_q.push_back(exp);
    lat = 0;
    while (!s_req_ready && lat < 20) begin
      step();
      lat++;
    end
    cfg_clear = clr_accept;
    step();
    s_req_valid = 0;
    cfg_clear = clr_a;
    lat = 0;
    while (!m_axis_timestamp_tvalid && lat < 20) begin
      step();
      lat++;
      cfg_clear = 0;
    end
    cfg_clear = 0;
    chk("latency", 72'(lat), 72'd3);
    held = m_axis_timestamp_tdata;
    pc = stat_pass_count;
    dc = stat_drop_count;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_tvalid", 72'(m_axis_timestamp_tvalid), 72'd1);
      chk("hold_tdata", m_axis_timestamp_tdata, held);
      chk("hold_ready", 72'(s_req_ready), 72'd0);
      chk("hold_counts", {8'd0, stat_pass_count, stat_drop_count}, {8'd0, pc, dc});
    end
    if (exp_q.size() > 0) chk("tdata", m_axis_timestamp_tdata, exp_q.pop_front());
    else chk("scoreboard_empty", 72'd1, 72'd0);
    m_axis_timestamp_tready = 1;
    step();
    m_axis_timestamp_tready = 0;
    chk("post_tvalid", 72'(m_axis_timestamp_tvalid), 72'd0);
    chk("post_ready", 72'(s_req_ready), 72'd1);
  endtask
  initial begin
    do_reset();
    chk("rst_ready", 72'(s_req_ready), 72'd1);
    chk("rst_tvalid", 72'(m_axis_timestamp_tvalid), 72'd0);
    chk("rst_tdata", m_axis_timestamp_tdata, 72'd0);
    chk("rst_pass", 72'(stat_pass_count), 72'd0);
    chk("rst_drop", 72'(stat_drop_count), 72'd0);
    req(1000, 100, 1000, 0, 0, 0);
    chk("pass1", 72'(stat_pass_count), 72'd1);
    req(1000, 1500, 12800, 0, 0, 0);
    cfg_max_residence = 1000;
    req(1000, 1500, 0, 0, 0, 0);
    chk("drop1", 72'(stat_drop_count), 72'd1);
    chk("pass2", 72'(stat_pass_count), 72'd2);
    cfg_max_residence = 100000;
    req(1000, 0, 12800, 0, 0, 0);
    req(20000, 0, 20000, 0, 0, 10);
    chk("pass_after_hold", 72'(stat_pass_count), 72'd4);
    do_reset();
    req(1000, 100, 1000, 0, 0, 0);
    req(1000000, 100, 1000000, 0, 0, 0);
    cfg_max_residence = 2000000;
    req(0, 2000, 1004800, 0, 0, 0);
    cfg_max_residence = 100000;
    do_reset();
    req(1000, 100, 1000, 0, 0, 0);
    req(1000, 100, 1600, 1, 0, 0);
    req(5, 0, 5, 0, 0, 0);
    do_reset();
    req(0, 0, 1, 0, 0, 0);
    chk("zero_forced_pass", 72'(stat_pass_count), 72'd1);
    req(1000, 100, 1000, 0, 0, 0);
    req(5, 0, 5, 0, 1, 0);
    s_req_arrival = 3000;
    s_req_length = 10;
    s_req_valid = 1;
    step();
    s_req_valid = 0;
    step();
    rstn = 0;
    step();
    chk("midrst_tvalid", 72'(m_axis_timestamp_tvalid), 72'd0);
    chk("midrst_ready", 72'(s_req_ready), 72'd1);
    chk("midrst_counts", {8'd0, stat_pass_count, stat_drop_count}, 72'd0);
    rstn = 1;
    req(7, 0, 7, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
